// File: rtl/macro.sv
`default_nettype none
// ============================================================================
//  Module      : macro
//  Description : 64-row x 8-column array of 4-bit weights with a row-wise
//                write/read-back port and a single-cycle compute path. Every
//                column forms the dot product of the 64 activations with its
//                64 weights and registers it as a 14-bit partial sum.
//
//  Ports
//    clk        in   1    clock, all state updates on the rising edge
//    rst        in   1    synchronous active-high reset
//    STDW       in   1    weight-write enable (row STD_A <= weight_in)
//    STDR       in   1    weight-read enable (weight_out <= row STD_A)
//    STD_A      in   6    row address 0..63
//    weight_in  in   32   eight 4-bit weights, column c = [4c+3:4c]
//    act_in     in   256  sixty-four 4-bit activations, row r = [4r+3:4r]
//    weight_out out  32   registered read-back of one row
//    PSUM       out  112  eight 14-bit partial sums, column c = [14c+13:14c]
//
//  Build option
//    MACRO_SIGNED_EN  defined   : weights/activations are 4-bit two's
//                                 complement, PSUM is 14-bit two's complement
//                     undefined : everything unsigned (default)
//
//  Revision    : 1.0  initial release
// ============================================================================
module macro (
    input  logic         clk,
    input  logic         rst,
    input  logic         STDW,
    input  logic         STDR,
    input  logic [5:0]   STD_A,
    input  logic [31:0]  weight_in,
    input  logic [255:0] act_in,
    output logic [31:0]  weight_out,
    output logic [111:0] PSUM
);

    localparam int c_ROWS = 64;
    localparam int c_COLS = 8;
    localparam int c_PSW  = 14;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0]      r_mem [0:c_ROWS-1];
    logic [31:0]      r_weight_out;
    logic [c_PSW-1:0] r_psum [0:c_COLS-1];
    logic [c_PSW-1:0] w_col_sum [0:c_COLS-1];

    logic w_compute;
    logic w_read;

    assign w_compute = ~STDW & ~STDR;
    // A simultaneous write wins; the read is dropped and weight_out holds.
    assign w_read    = STDR & ~STDW;

    // ------------------------------------------------------------------------
    // One product term, extended to the partial-sum width. In the signed
    // build both operands are sign-extended so the 14-bit modular sum is the
    // exact two's-complement result (|sum| never exceeds 4096).
    // ------------------------------------------------------------------------
    function automatic logic [c_PSW-1:0] f_term(input logic [3:0] a,
                                                input logic [3:0] w);
        logic [c_PSW-1:0] a_x;
        logic [c_PSW-1:0] w_x;
`ifdef MACRO_SIGNED_EN
        a_x = {{(c_PSW-4){a[3]}}, a};
        w_x = {{(c_PSW-4){w[3]}}, w};
`else
        a_x = {{(c_PSW-4){1'b0}}, a};
        w_x = {{(c_PSW-4){1'b0}}, w};
`endif
        return a_x * w_x;
    endfunction

    // ------------------------------------------------------------------------
    // Column dot products, evaluated from the array contents before the edge
    // so a same-cycle write only affects the next compute.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < c_COLS; c++) begin
            w_col_sum[c] = '0;
            for (int r = 0; r < c_ROWS; r++) begin
                w_col_sum[c] = w_col_sum[c]
                             + f_term(act_in[4*r +: 4], r_mem[r][4*c +: 4]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Weight array
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < c_ROWS; r++) begin
                r_mem[r] <= '0;
            end
        end else if (STDW) begin
            r_mem[STD_A] <= weight_in;
        end
    end

    // ------------------------------------------------------------------------
    // Read-back register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight_out <= '0;
        end else if (w_read) begin
            r_weight_out <= r_mem[STD_A];
        end
    end

    // ------------------------------------------------------------------------
    // Partial-sum registers: updated only in compute mode, held otherwise
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < c_COLS; c++) begin
                r_psum[c] <= '0;
            end
        end else if (w_compute) begin
            for (int c = 0; c < c_COLS; c++) begin
                r_psum[c] <= w_col_sum[c];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------------
    assign weight_out = r_weight_out;

    generate
        for (genvar gc = 0; gc < c_COLS; gc++) begin : g_pack
            assign PSUM[c_PSW*gc +: c_PSW] = r_psum[gc];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_macro.sv
`default_nettype none
// ============================================================================
//  Module      : tb_macro
//  Description : Self-checking bench for macro. Directed scenarios plus a
//                randomized run compared against an integer reference model
//                of the weight array, read-back register and partial sums.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_macro;

    logic         clk;
    logic         rst;
    logic         STDW;
    logic         STDR;
    logic [5:0]   STD_A;
    logic [31:0]  weight_in;
    logic [255:0] act_in;
    logic [31:0]  weight_out;
    logic [111:0] PSUM;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (weights held as integer values)
    int          m_w [64][8];
    logic [31:0] m_wout;
    int          m_psum [8];

    macro dut (
        .clk        (clk),
        .rst        (rst),
        .STDW       (STDW),
        .STDR       (STDR),
        .STD_A      (STD_A),
        .weight_in  (weight_in),
        .act_in     (act_in),
        .weight_out (weight_out),
        .PSUM       (PSUM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nib(input logic [3:0] v);
`ifdef MACRO_SIGNED_EN
        return v[3] ? int'(v) - 16 : int'(v);
`else
        return int'(v);
`endif
    endfunction

    // Apply one rising edge with the current inputs to both DUT and model,
    // then leave the bench 1 time unit after the edge.
    task automatic step();
        int          ps [8];
        logic [31:0] row;
        for (int c = 0; c < 8; c++) begin
            ps[c] = 0;
            for (int r = 0; r < 64; r++)
                ps[c] += nib(act_in[4*r +: 4]) * m_w[r][c];
        end
        row = '0;
        for (int c = 0; c < 8; c++) row[4*c +: 4] = 4'(m_w[STD_A][c]);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 8; c++) m_w[r][c] = 0;
            m_wout = '0;
            for (int c = 0; c < 8; c++) m_psum[c] = 0;
        end else begin
            if (STDR && !STDW) m_wout = row;
            if (!STDW && !STDR)
                for (int c = 0; c < 8; c++) m_psum[c] = ps[c];
            if (STDW)
                for (int c = 0; c < 8; c++) m_w[STD_A][c] = nib(weight_in[4*c +: 4]);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; STDW = 1'b0; STDR = 1'b0; STD_A = '0;
        weight_in = '0; act_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; STDW = 1'b1; STDR = 1'b1; weight_in = 32'hDEADBEEF;
        step();
        step();
        rst = 1'b0; STDW = 1'b0; STDR = 1'b0;
        n_checks++;
        if (weight_out !== 32'h0)
            $display("FAIL reset_wout got %h exp %h", weight_out, 32'h0);
        else n_pass++;
        n_checks++;
        if (PSUM !== 112'h0)
            $display("FAIL reset_psum got %h exp 0", PSUM);
        else n_pass++;
    endtask

    task automatic test_load_compute();
        int exp_c [8];
        idle_inputs();
        STDW = 1'b1; weight_in = 32'h01234567;
        for (int a = 1; a < 64; a++) begin
            STD_A = 6'(a);
            step();
        end
        STD_A = 6'd0;
        step();
        STDW = 1'b0; act_in = '1;
        step();
        for (int c = 0; c < 8; c++) begin
`ifdef MACRO_SIGNED_EN
            exp_c[c] = -64 * (7 - c);
`else
            exp_c[c] = 960 * (7 - c);
`endif
            n_checks++;
            if (PSUM[14*c +: 14] !== 14'(exp_c[c]))
                $display("FAIL load_compute_col%0d got %0d exp %0d", c, PSUM[14*c +: 14], 14'(exp_c[c]));
            else n_pass++;
        end
        // Read row 35, PSUM must hold during the read cycle
        act_in = '0; STDR = 1'b1; STD_A = 6'd35;
        step();
        STDR = 1'b0;
        n_checks++;
        if (weight_out !== 32'h01234567)
            $display("FAIL read_row35 got %h exp %h", weight_out, 32'h01234567);
        else n_pass++;
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (PSUM[14*c +: 14] !== 14'(exp_c[c]))
                $display("FAIL read_hold_col%0d got %0d exp %0d", c, PSUM[14*c +: 14], 14'(exp_c[c]));
            else n_pass++;
        end
    endtask

    task automatic test_max();
        int exp_v;
        idle_inputs();
        STDW = 1'b1; weight_in = 32'hFFFFFFFF;
        for (int a = 0; a < 64; a++) begin
            STD_A = 6'(a);
            step();
        end
        STDW = 1'b0; act_in = '1;
        step();
`ifdef MACRO_SIGNED_EN
        exp_v = 64;
`else
        exp_v = 14400;
`endif
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (PSUM[14*c +: 14] !== 14'(exp_v))
                $display("FAIL max_col%0d got %0d exp %0d", c, PSUM[14*c +: 14], exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        logic [111:0] held;
        idle_inputs();
        STDW = 1'b1; STD_A = 6'd5; weight_in = 32'h0;
        step();
        STD_A = 6'd7; weight_in = 32'h13579BDF;
        step();
        STDW = 1'b0; STDR = 1'b1;
        step();
        held = PSUM;
        STDW = 1'b1; STDR = 1'b1; STD_A = 6'd5; weight_in = 32'hFFFFFFFF;
        step();
        n_checks++;
        if (weight_out !== 32'h13579BDF)
            $display("FAIL collision_wout_hold got %h exp %h", weight_out, 32'h13579BDF);
        else n_pass++;
        n_checks++;
        if (PSUM !== m_psum_packed())
            $display("FAIL collision_psum_hold got %h exp %h", PSUM, m_psum_packed());
        else n_pass++;
        STDW = 1'b0; STDR = 1'b1; weight_in = 32'h0;
        step();
        STDR = 1'b0;
        n_checks++;
        if (weight_out !== 32'hFFFFFFFF)
            $display("FAIL collision_readback got %h exp %h", weight_out, 32'hFFFFFFFF);
        else n_pass++;
        n_checks++;
        if (PSUM !== held)
            $display("FAIL collision_psum_unchanged got %h exp %h", PSUM, held);
        else n_pass++;
    endtask

    function automatic logic [111:0] m_psum_packed();
        logic [111:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[14*c +: 14] = 14'(m_psum[c]);
        return v;
    endfunction

    task automatic test_random();
        int r;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            r         = int'($urandom_range(0, 99));
            rst       = (r < 3);
            STDW      = ($urandom_range(0, 3) == 0);
            STDR      = ($urandom_range(0, 3) == 0);
            STD_A     = 6'($urandom_range(0, 63));
            weight_in = $urandom;
            for (int k = 0; k < 8; k++) act_in[32*k +: 32] = $urandom;
            step();
            n_checks++;
            if (weight_out !== m_wout)
                $display("FAIL random_wout cyc %0d got %h exp %h", i, weight_out, m_wout);
            else n_pass++;
            n_checks++;
            if (PSUM !== m_psum_packed())
                $display("FAIL random_psum cyc %0d got %h exp %h", i, PSUM, m_psum_packed());
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        STDW = 1'b1;
        for (int a = 0; a < 64; a++) begin
            STD_A = 6'(a); weight_in = $urandom | 32'h11111111;
            step();
        end
        STDW = 1'b0; STDR = 1'b1; STD_A = 6'd9;
        step();
        STDR = 1'b0; act_in = '1;
        step();
        // reset together with a pending write
        rst = 1'b1; STDW = 1'b1; STD_A = 6'd3; weight_in = 32'h77777777;
        step();
        rst = 1'b0; STDW = 1'b0;
        n_checks++;
        if (weight_out !== 32'h0)
            $display("FAIL midreset_wout got %h exp 0", weight_out);
        else n_pass++;
        n_checks++;
        if (PSUM !== 112'h0)
            $display("FAIL midreset_psum got %h exp 0", PSUM);
        else n_pass++;
        act_in = '1;
        step();
        n_checks++;
        if (PSUM !== 112'h0)
            $display("FAIL postreset_compute got %h exp 0", PSUM);
        else n_pass++;
    endtask

`ifdef MACRO_SIGNED_EN
    task automatic test_signed();
        idle_inputs();
        STDW = 1'b1; weight_in = 32'h88888888;
        for (int a = 0; a < 64; a++) begin
            STD_A = 6'(a);
            step();
        end
        STDW = 1'b0; act_in = {64{4'h8}};
        step();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (PSUM[14*c +: 14] !== 14'(4096))
                $display("FAIL signed_min_col%0d got %0d exp 4096", c, $signed(PSUM[14*c +: 14]));
            else n_pass++;
        end
        act_in = {64{4'h7}};
        step();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (PSUM[14*c +: 14] !== 14'(-3584))
                $display("FAIL signed_neg_col%0d got %0d exp -3584", c, $signed(PSUM[14*c +: 14]));
            else n_pass++;
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_compute();
        test_max();
        test_collision();
        test_random();
        test_mid_reset();
`ifdef MACRO_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/macro.md
MACRO -- requirements
Module: macro

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the port STDW, input, 1 bit: weight-write enable.
REQ-004 The module SHALL have the port STDR, input, 1 bit: weight-read enable.
REQ-005 The module SHALL have the port STD_A, input, 6 bits: row address 0..63 for write and read.
REQ-006 The module SHALL have the port weight_in, input, 32 bits: eight 4-bit weights; column c = weight_in[4c+3:4c].
REQ-007 The module SHALL have the port act_in, input, 256 bits: sixty-four 4-bit activations; row r = act_in[4r+3:4r].
REQ-008 The module SHALL have the port weight_out, output, 32 bits: registered read-back of one row, same column packing as weight_in.
REQ-009 The module SHALL have the port PSUM, output, 112 bits: eight 14-bit partial sums; column c = PSUM[14c+13:14c].

Function
REQ-010 The module SHALL hold a 64-row x 8-column array of 4-bit weights (2048 bits).
REQ-011 When STDW=1 at a rising edge, row STD_A SHALL be loaded with weight_in; the other rows SHALL be unchanged.
REQ-012 When STDR=1 and STDW=0 at a rising edge, weight_out SHALL be loaded with row STD_A (1-cycle latency); otherwise weight_out SHALL hold.
REQ-013 When STDW=1 and STDR=1 together, the write SHALL take effect, the read SHALL be ignored, and weight_out SHALL hold.
REQ-014 Compute mode is STDW=0 and STDR=0; at each rising edge in this mode, PSUM column c SHALL be loaded with the sum over r=0..63 of act_in[r] x W[r][c] (1-cycle latency from act_in).
REQ-015 In any cycle with STDW=1 or STDR=1, PSUM SHALL hold its previous value.
REQ-016 Compute SHALL use the array contents present before the edge; a write takes effect for the first compute in the following cycle.
REQ-017 Arithmetic SHALL be exact: each product is 8 bits and the 64-term sum fits 14 bits (unsigned maximum 64x15x15 = 14400); no saturation or truncation is required.
REQ-018 STD_A SHALL cover the full range 0..63 with no out-of-range case.

Reset
REQ-019 When rst=1 at a rising edge, all array rows, weight_out and PSUM SHALL become 0, overriding STDW and STDR in that cycle.
REQ-020 A reset asserted mid-sequence SHALL discard any pending write, read or compute; operation SHALL resume on the first edge after rst=0.

Configuration
REQ-021 Macro MACRO_SIGNED_EN undefined: weights, activations and PSUM SHALL be unsigned.
REQ-022 Macro MACRO_SIGNED_EN defined: weights and activations SHALL be 4-bit two's complement (-8..7) and PSUM SHALL be 14-bit two's complement (range -3584..4096); storage, read-back and timing SHALL be unchanged.

Verification
REQ-023 Test: write rows 1..63 then row 0 with weight_in=0x01234567, then compute with act_in all ones -> PSUM columns 0..7 = 6720, 5760, 4800, 3840, 2880, 1920, 960, 0 one cycle later.
REQ-024 Test: after the load in REQ-023, STDR=1 with STD_A=35 -> weight_out=0x01234567 on the next cycle; PSUM held during that cycle.
REQ-025 Test: all weights 0xF and all activations 0xF, unsigned build -> every PSUM column = 14400.
REQ-026 Test: STDW=1 and STDR=1 with STD_A=5 and weight_in=0xFFFFFFFF -> row 5 written, weight_out unchanged; a read of row 5 on the next cycle returns 0xFFFFFFFF.
REQ-027 Test: rst=1 after loading weights -> weight_out=0 and PSUM=0; compute with all-ones act_in afterwards -> PSUM all 0.
REQ-028 Test: MACRO_SIGNED_EN build, all weights 0x8 and all activations 0x8 -> each PSUM column = 4096; with activations 0x7 instead -> each column = -3584.
